// File: rtl/counter_pkg.sv
// Shared encodings for the counter_dx up/down counter: limit modes and run state.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

endpackage

// File: rtl/counter_dx_next.sv
// Combinational next-value and limit-event datapath for counter_dx.
module counter_dx_next
  import counter_pkg::*;
#(
  parameter int WIDTH  = 36,
  parameter int STEP_W = 9
) (
  input  logic [WIDTH-1:0]  cnt,
  input  logic [STEP_W-1:0] step,
  input  logic              updown,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  min_count,
  input  logic [WIDTH-1:0]  max_count,
  output logic [WIDTH-1:0]  next_cnt,
  output logic              limit_evt
);

  logic [WIDTH:0] step_ext_s;
  logic [WIDTH:0] cand_up_s;
  logic [WIDTH:0] cand_dn_s;

  // One extra bit keeps the carry (up) and the sign (down) for limit compare
  assign step_ext_s = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign cand_up_s  = {1'b0, cnt} + step_ext_s;
  assign cand_dn_s  = {1'b0, cnt} - step_ext_s;

  // Candidate selection and limit substitution per mode
  always_comb begin
    next_cnt  = cnt;
    limit_evt = 1'b0;
    if (step == {STEP_W{1'b0}}) begin
      next_cnt  = cnt;
      limit_evt = 1'b0;
    end else if (updown) begin
      if (cand_up_s > {1'b0, max_count}) begin
        limit_evt = 1'b1;
        case (mode_e'(mode))
          MODE_SAT, MODE_ONESHOT: next_cnt = max_count;
          default:                next_cnt = min_count;
        endcase
      end else begin
        next_cnt = cand_up_s[WIDTH-1:0];
      end
    end else begin
      if ($signed(cand_dn_s) < $signed({1'b0, min_count})) begin
        limit_evt = 1'b1;
        case (mode_e'(mode))
          MODE_SAT, MODE_ONESHOT: next_cnt = min_count;
          default:                next_cnt = max_count;
        endcase
      end else begin
        next_cnt = cand_dn_s[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/counter_dx.sv
// Up/down counter with WRAP/SAT/ONESHOT limit handling, load and terminal-count pulse.
module counter_dx
  import counter_pkg::*;
#(
  parameter int WIDTH  = 36,
  parameter int STEP_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              updown,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  min_count,
  input  logic [WIDTH-1:0]  max_count,
  input  logic [1:0]        mode,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  cnt,
  output logic              tc,
  output logic              done,
  output logic              cfg_err
);

  state_e           state_r, state_nx_s;
  logic [WIDTH-1:0] cnt_r, cnt_nx_s, next_s;
  logic             tc_r, tc_nx_s;
  logic             done_r, done_nx_s;
  logic             cfg_err_r, cfg_err_nx_s;
  logic             evt_s;

  counter_dx_next #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_next (
    .cnt       (cnt_r),
    .step      (step),
    .updown    (updown),
    .mode      (mode),
    .min_count (min_count),
    .max_count (max_count),
    .next_cnt  (next_s),
    .limit_evt (evt_s)
  );

  // Next-state and next-output logic: load beats counting, counting needs RUN and sane limits
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    tc_nx_s      = 1'b0;
    done_nx_s    = done_r;
    cfg_err_nx_s = (min_count > max_count);
    if (load) begin
      cnt_nx_s   = load_val;
      done_nx_s  = 1'b0;
      state_nx_s = ST_RUN;
    end else if (ena && (state_r == ST_RUN) && !cfg_err_r) begin
      cnt_nx_s = next_s;
      tc_nx_s  = evt_s;
      if (evt_s && (mode_e'(mode) == MODE_ONESHOT)) begin
        done_nx_s  = 1'b1;
        state_nx_s = ST_HALT;
      end else begin
        state_nx_s = state_r;
      end
    end else begin
      cnt_nx_s = cnt_r;
    end
  end

  // State and output registers; reset reloads from the live min_count
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_RUN;
      cnt_r     <= min_count;
      tc_r      <= 1'b0;
      done_r    <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      tc_r      <= tc_nx_s;
      done_r    <= done_nx_s;
      cfg_err_r <= cfg_err_nx_s;
    end
  end

  assign cnt     = cnt_r;
  assign tc      = tc_r;
  assign done    = done_r;
  assign cfg_err = cfg_err_r;

endmodule

// File: tb/tb_counter_dx.sv
// Scoreboard bench for counter_dx: driver queues hand-computed expectations, monitor compares.
module tb_counter_dx;

  localparam int WIDTH  = 36;
  localparam int STEP_W = 9;
  localparam logic [WIDTH-1:0] MAXV  = 36'hF_FFFF_FFFF;
  localparam logic [WIDTH-1:0] NEARV = 36'hF_FFFF_FFFB;

  typedef struct packed {
    logic [WIDTH-1:0] cnt;
    logic             tc;
    logic             done;
    logic             cfg_err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst, ena, updown, load;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  min_count, max_count, load_val;
  logic [1:0]        mode;
  logic [WIDTH-1:0]  cnt;
  logic              tc, done, cfg_err;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  counter_dx #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .updown(updown), .step(step),
    .min_count(min_count), .max_count(max_count), .mode(mode),
    .load(load), .load_val(load_val),
    .cnt(cnt), .tc(tc), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every negedge after a queued edge, compare all outputs
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("cnt",     cnt,                     e.cnt);
      chk("tc",      {35'd0, tc},             {35'd0, e.tc});
      chk("done",    {35'd0, done},           {35'd0, e.done});
      chk("cfg_err", {35'd0, cfg_err},        {35'd0, e.cfg_err});
    end
  end

  task automatic cyc(input logic [WIDTH-1:0] e_cnt, input logic e_tc, input logic e_done,
                     input logic e_cfg);
    exp_t e;
    @(posedge clk);
    e.cnt = e_cnt; e.tc = e_tc; e.done = e_done; e.cfg_err = e_cfg;
    exp_q.push_back(e);
    #1;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; updown = 1'b1; load = 1'b0; step = 9'd3;
    min_count = 36'd0; max_count = 36'd9; load_val = 36'd0; mode = 2'd0;
    cyc(36'd0, 1'b0, 1'b0, 1'b0);

    // WRAP up 0..9 step 3
    rst = 1'b0; ena = 1'b1;
    cyc(36'd3, 1'b0, 1'b0, 1'b0);
    cyc(36'd6, 1'b0, 1'b0, 1'b0);
    cyc(36'd9, 1'b0, 1'b0, 1'b0);
    cyc(36'd0, 1'b1, 1'b0, 1'b0);
    ena = 1'b0;
    cyc(36'd0, 1'b0, 1'b0, 1'b0);

    // SAT down 5..20 step 4 from 11
    mode = 2'd1; updown = 1'b0; min_count = 36'd5; max_count = 36'd20; step = 9'd4;
    load = 1'b1; load_val = 36'd11;
    cyc(36'd11, 1'b0, 1'b0, 1'b0);
    load = 1'b0; ena = 1'b1;
    cyc(36'd7, 1'b0, 1'b0, 1'b0);
    cyc(36'd5, 1'b1, 1'b0, 1'b0);
    cyc(36'd5, 1'b1, 1'b0, 1'b0);
    ena = 1'b0;
    cyc(36'd5, 1'b0, 1'b0, 1'b0);

    // ONESHOT up 0..100 step 60
    mode = 2'd2; updown = 1'b1; min_count = 36'd0; max_count = 36'd100; step = 9'd60;
    load = 1'b1; load_val = 36'd0;
    cyc(36'd0, 1'b0, 1'b0, 1'b0);
    load = 1'b0; ena = 1'b1;
    cyc(36'd60, 1'b0, 1'b0, 1'b0);
    cyc(36'd100, 1'b1, 1'b1, 1'b0);
    cyc(36'd100, 1'b0, 1'b1, 1'b0);
    cyc(36'd100, 1'b0, 1'b1, 1'b0);
    load = 1'b1; load_val = 36'd0;
    cyc(36'd0, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    cyc(36'd60, 1'b0, 1'b0, 1'b0);

    // load beats ena, then reset out of HALT reloads live min_count
    load = 1'b1; load_val = 36'd50;
    cyc(36'd50, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    cyc(36'd100, 1'b1, 1'b1, 1'b0);
    rst = 1'b1; min_count = 36'd7;
    cyc(36'd7, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(36'd67, 1'b0, 1'b0, 1'b0);

    // Full-width wrap needs the carry bit
    mode = 2'd0; updown = 1'b1; min_count = 36'd12; max_count = MAXV; step = 9'd511;
    ena = 1'b0; load = 1'b1; load_val = NEARV;
    cyc(NEARV, 1'b0, 1'b0, 1'b0);
    load = 1'b0; ena = 1'b1;
    cyc(36'd12, 1'b1, 1'b0, 1'b0);

    // step 0 outside limits holds; down below zero needs the sign bit
    load = 1'b1; load_val = 36'd3;
    cyc(36'd3, 1'b0, 1'b0, 1'b0);
    load = 1'b0; step = 9'd0;
    cyc(36'd3, 1'b0, 1'b0, 1'b0);
    step = 9'd5; updown = 1'b0;
    cyc(MAXV, 1'b1, 1'b0, 1'b0);

    // Inverted limits: counting frozen, load still works
    min_count = 36'd10; max_count = 36'd3; ena = 1'b0; step = 9'd1; updown = 1'b1;
    cyc(MAXV, 1'b0, 1'b0, 1'b1);
    ena = 1'b1;
    cyc(MAXV, 1'b0, 1'b0, 1'b1);
    load = 1'b1; load_val = 36'd4;
    cyc(36'd4, 1'b0, 1'b0, 1'b1);
    load = 1'b0; ena = 1'b0; max_count = 36'd100;
    cyc(36'd4, 1'b0, 1'b0, 1'b0);
    min_count = 36'd0; ena = 1'b1;
    cyc(36'd5, 1'b0, 1'b0, 1'b0);
    ena = 1'b0;

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_dx.md
COUNTER_DX -- requirements
Module: counter_dx

Interface
REQ-001 Parameter WIDTH, default 36: counter and limit width in bits.
REQ-002 Parameter STEP_W, default 9: step width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ena  input  1  count enable; one step per enabled cycle.
REQ-006 updown  input  1  1 = count up, 0 = count down.
REQ-007 step  input  STEP_W  unsigned increment per enabled cycle.
REQ-008 min_count  input  WIDTH  lower limit, unsigned.
REQ-009 max_count  input  WIDTH  upper limit, unsigned.
REQ-010 mode  input  2  limit behaviour: 0 WRAP, 1 SAT, 2 ONESHOT, 3 treated as WRAP.
REQ-011 load  input  1  synchronous load strobe.
REQ-012 load_val  input  WIDTH  value written on load.
REQ-013 cnt  output  WIDTH  registered count.
REQ-014 tc  output  1  one-cycle terminal-count pulse, registered.
REQ-015 done  output  1  ONESHOT completion flag, registered.
REQ-016 cfg_err  output  1  registered flag: min_count > max_count.

Function
REQ-017 Update priority each cycle SHALL be: rst > load > (ena and state RUN) > hold.
REQ-018 States SHALL be RUN and HALT; RUN -> HALT on a limit event in ONESHOT; HALT -> RUN only on load or rst.
REQ-019 Up candidate SHALL be cnt + step in WIDTH+1 bits; limit event when candidate > max_count.
REQ-020 Down candidate SHALL be cnt - step in WIDTH+1 bits, signed; limit event when candidate < min_count.
REQ-021 No limit event: cnt <= candidate; landing exactly on a limit SHALL NOT be an event.
REQ-022 Event in WRAP: cnt <= min_count (up) or max_count (down).
REQ-023 Event in SAT: cnt <= max_count (up) or min_count (down); repeated steps at the limit raise further events.
REQ-024 Event in ONESHOT: cnt <= the limit reached, done <= 1, state <= HALT.
REQ-025 tc SHALL be 1 in the cycle after any limit event, otherwise 0; latency from event cycle to tc = 1 clock.
REQ-026 In HALT, ena SHALL be ignored: cnt held, tc = 0, done held at 1.
REQ-027 load SHALL write load_val unmodified, even outside [min_count, max_count], clear done, force RUN, with tc = 0 that cycle.
REQ-028 load asserted together with ena SHALL perform the load only.
REQ-029 step = 0 with ena SHALL hold cnt with no event, including when cnt lies outside the limits.
REQ-030 While cfg_err is 1, enabled counting SHALL hold cnt with tc = 0; load remains functional.
REQ-031 updown and mode changes SHALL take effect on the next enabled cycle without glitching outputs.

Reset
REQ-032 In a cycle with rst = 1: cnt <= min_count sampled that cycle, tc <= 0, done <= 0, cfg_err <= 0, state <= RUN.
REQ-033 rst mid-ONESHOT or in HALT SHALL return to RUN with done cleared.

Structure
REQ-034 Mode encodings (MODE_WRAP, MODE_SAT, MODE_ONESHOT) and state encodings SHALL reside in shared package counter_pkg.
REQ-035 The limit-detect/next-value datapath SHALL be a sub-module, counter_dx_next, combinational and parameterised by WIDTH and STEP_W.
REQ-036 All outputs SHALL be driven directly from flops.

Verification
REQ-037 WRAP up: min 0, max 9, step 3, cnt 0, ena 4 cycles -> cnt 3,6,9,0; tc = 1 only in the cycle after the 9->0 step.
REQ-038 SAT down: min 5, max 20, step 4, load 11, then ena 3 cycles -> cnt 7,5,5; tc pulses after the 2nd and 3rd steps.
REQ-039 ONESHOT up: min 0, max 100, step 60, from 0 -> cnt 60,100, done = 1; further ena holds 100; load 0 clears done and counting resumes.
REQ-040 load and ena both high, load_val 50 -> cnt 50, tc 0; rst with min_count 7 -> cnt 7, done 0, tc 0.
REQ-041 WIDTH = 36, max 2^36-1, up step 511 from 2^36-5 -> WRAP to min_count with no carry-out corruption; min 10, max 3 -> cfg_err 1, cnt held.
